// File: rtl/circ_rotl_seq_alu_if.sv
// Handshake/operand bundle for the sequential rotate-left unit.
// The requester (master) drives start/A/B. The unit (slave) returns O/busy/done.
interface circ_rotl_seq_alu_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [DATA_W-1:0] O;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output A,
        output B,
        input  O,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        output O,
        output busy,
        output done
    );
endinterface

// File: rtl/circ_rotl_seq_alu.sv
// Multi-cycle circular rotate-left of the low ROT_W bits of A by B, one position per clock.
// This is the inverse of the ALU's rotate-right. Upper bits pass through. start/busy/done handshake.
module circ_rotl_seq_alu #(
    parameter int DATA_W = 32,
    parameter int ROT_W  = 8
) (
    input logic                clk,
    input logic                rst,
    circ_rotl_seq_alu_if.slave bus
);
    localparam int CNT_W = (ROT_W > 1) ? $clog2(ROT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROT  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [DATA_W-1:0] work_reg;
    logic [DATA_W-1:0] rot_next;
    logic [DATA_W-1:0] o_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              b_in_range;
    logic              last_step;

    // Out-of-range amounts (0 or >= ROT_W, compared on the full word) are treated as identity.
    assign b_in_range = (bus.B != '0) && (bus.B < DATA_W'(ROT_W));
    assign last_step  = (cnt_reg == CNT_W'(1));

    // One-position left rotate of the low field; the bit that leaves at the top wraps to bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < ROT_W; gi++) begin : g_rot
            assign rot_next[gi] = work_reg[(gi + ROT_W - 1) % ROT_W];
        end
        if (ROT_W < DATA_W) begin : g_upper
            assign rot_next[DATA_W-1:ROT_W] = work_reg[DATA_W-1:ROT_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = b_in_range ? S_ROT : S_DONE;
                end
            end
            S_ROT: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_reg)
            S_ROT:  bus.busy = 1'b1;
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // O is loaded only on the edge that enters DONE, so it holds the last result while idle or rotating.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg <= '0;
            cnt_reg  <= '0;
            o_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        work_reg <= bus.A;
                        if (b_in_range) begin
                            cnt_reg <= bus.B[CNT_W-1:0];
                        end else begin
                            cnt_reg <= '0;
                            o_reg   <= bus.A;
                        end
                    end
                end
                S_ROT: begin
                    work_reg <= rot_next;
                    cnt_reg  <= cnt_reg - CNT_W'(1);
                    if (last_step) begin
                        o_reg <= rot_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.O = o_reg;
endmodule

// File: tb/tb_circ_rotl_seq_alu.sv
// Self-checking bench for circ_rotl_seq_alu: vector table, hand-built corner sequences,
// and randomized round trips through a rotate-right reference model.
module tb_circ_rotl_seq_alu;
    localparam int DATA_W = 32;
    localparam int ROT_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    circ_rotl_seq_alu_if #(.DATA_W(DATA_W)) bus ();

    circ_rotl_seq_alu #(.DATA_W(DATA_W), .ROT_W(ROT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_o;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference rotates are arithmetic on the low field, not bit-by-bit shifting.
    function automatic logic [31:0] eff_amt(input logic [31:0] b);
        return (b >= 1 && b < ROT_W) ? b : 32'd0;
    endfunction

    function automatic logic [31:0] rotl_ref(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] mask = (32'd1 << ROT_W) - 32'd1;
        logic [31:0] low  = a & mask;
        logic [31:0] r    = ((low << k) | (low >> (ROT_W - k))) & mask;
        return (a & ~mask) | r;
    endfunction

    function automatic logic [31:0] rotr_ref(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] mask = (32'd1 << ROT_W) - 32'd1;
        logic [31:0] low  = a & mask;
        logic [31:0] r    = ((low >> k) | (low << (ROT_W - k))) & mask;
        return (a & ~mask) | r;
    endfunction

    function automatic int lat_ref(input logic [31:0] b);
        return (eff_amt(b) == 0) ? 1 : int'(eff_amt(b)) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and waits (bounded) for done; returns to IDLE before exit.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] o, output int lat,
                          output bit o_moved, output int busy_cycles);
        logic [31:0] prev_o;
        prev_o      = bus.O;
        bus.A       = a;
        bus.B       = b;
        bus.start   = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.A       = $urandom;
        bus.B       = $urandom;
        lat         = 1;
        o_moved     = 1'b0;
        busy_cycles = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_cycles++;
            if (bus.O !== prev_o) o_moved = 1'b1;
            tick();
            lat++;
        end
        if (bus.busy) busy_cycles++;
        o = bus.O;
        tick();
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    logic [31:0] got_o;
    int          got_lat;
    bit          moved;
    int          bcyc;
    int          n_done;
    logic [31:0] hold_o;

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;

        vecs[0] = '{32'h123456A5, 32'd1,     32'h1234564B, 2};
        vecs[1] = '{32'hFFFF0081, 32'd7,     32'hFFFF00C0, 8};
        vecs[2] = '{32'hDEADBEEF, 32'd0,     32'hDEADBEEF, 1};
        vecs[3] = '{32'hDEADBEEF, 32'h9,     32'hDEADBEEF, 1};
        vecs[4] = '{32'h000000F0, 32'd4,     32'h0000000F, 5};
        vecs[5] = '{32'hAAAAAA01, 32'd8,     32'hAAAAAA01, 1};
        vecs[6] = '{32'h00000080, 32'h101,   32'h00000080, 1};
        vecs[7] = '{32'h12345601, 32'd2,     32'h12345604, 3};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_O", bus.O, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_done", {31'd0, bus.done}, 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, got_o, got_lat, moved, bcyc);
            $display("vec %0d: A=0x%08h B=0x%08h O=0x%08h lat=%0d busy_cycles=%0d",
                     i, vecs[i].a, vecs[i].b, got_o, got_lat, bcyc);
            check("vec_O", got_o, vecs[i].exp_o);
            check("vec_latency", got_lat, vecs[i].exp_lat);
            check("vec_busy_cycles", bcyc, vecs[i].exp_lat);
            check("vec_O_held_while_busy", {31'd0, moved}, 32'd0);
        end

        // Result must stay put across idle cycles.
        hold_o = bus.O;
        repeat (5) tick();
        check("O_held_idle", bus.O, 32'h12345604);
        $display("idle hold: O=0x%08h (was 0x%08h)", bus.O, hold_o);

        // Start pulse and operand changes while busy must be ignored.
        bus.A     = 32'h00000001;
        bus.B     = 32'd3;
        bus.start = 1'b1;
        tick();
        got_lat = 1;
        n_done  = 0;
        got_o   = '0;
        bus.start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    got_o = bus.O;
                    got_lat = i;
                end
            end
            bus.start = (i == 1);
            bus.A     = (i == 1) ? 32'hFF : $urandom;
            bus.B     = (i == 1) ? 32'd2  : $urandom_range(1, 7);
            if (i == 2) bus.start = 1'b0;
            tick();
        end
        bus.start = 1'b0;
        $display("busy-ignore: dones=%0d O=0x%08h lat=%0d", n_done, got_o, got_lat);
        check("busy_ignore_done_count", n_done, 32'd1);
        check("busy_ignore_O", got_o, 32'h00000008);
        check("busy_ignore_latency", got_lat, 32'd4);

        // Reset in the middle of a rotation aborts with no done pulse.
        bus.A     = 32'h000000FF;
        bus.B     = 32'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        check("midrst_O", bus.O, 32'd0);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) n_done++;
            tick();
        end
        $display("mid-op reset: O=0x%08h dones_after=%0d", bus.O, n_done);
        check("midrst_no_done", n_done, 32'd0);

        // Round trip: rotl(rotr(A,k),k) must give A back, with the rule latency.
        for (int t = 0; t < 1000; t++) begin
            logic [31:0] a;
            logic [31:0] k;
            logic [31:0] fed;
            a   = $urandom;
            k   = $urandom_range(0, ROT_W - 1);
            fed = rotr_ref(a, k);
            repeat ($urandom_range(0, 2)) tick();
            run_op(fed, k, got_o, got_lat, moved, bcyc);
            $display("rand %0d: A=0x%08h k=%0d fed=0x%08h O=0x%08h lat=%0d", t, a, k, fed, got_o, got_lat);
            check("rand_O_roundtrip", got_o, a);
            check("rand_O_model", got_o, rotl_ref(fed, eff_amt(k)));
            check("rand_latency", got_lat, lat_ref(k));
            check("rand_O_held_while_busy", {31'd0, moved}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
